rename_regfile: RTL and testbench

Parametrised architectural register file with rename tags. It sits between instruction decode and dispatch. On an accepted instruction it reads NRD source operands as value plus tag, renames the destination to the ROB-supplied tag, and presents everything through a one-entry registered output stage with valid/ready. Commits from the ROB write architectural data and clear matching tags. A flush drops all tags and the held output.

---
 rtl/rename_regfile_pkg.sv | 16 +
 rtl/rename_regfile_if.sv | 49 ++++
 rtl/rename_regfile_read_port.sv | 47 ++++
 rtl/rename_regfile.sv | 127 ++++++++++++
 tb/tb_rename_regfile.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rename_regfile_pkg.sv
// Shared defaults, the "not renamed" tag value, register-number width helper
// and the opaque decode payload type for the rename register file.
package rename_rf_pkg;
    localparam int DEF_XLEN  = 32;
    localparam int DEF_NREG  = 32;
    localparam int DEF_TAG_W = 4;
    localparam int DEF_NRD   = 2;
    localparam int DEF_PAY_W = 64;
    localparam int TAG_NONE  = 0;

    typedef logic [DEF_PAY_W-1:0] pay_t;

    function automatic int reg_w(input int nreg);
        return (nreg > 1) ? $clog2(nreg) : 1;
    endfunction
endpackage

// File: rtl/rename_regfile_if.sv
// Decode/commit/dispatch bundle of the rename register file. The master side
// is decode + ROB + dispatch; the slave side is the register file itself.
interface rename_regfile_if
    import rename_rf_pkg::*;
#(
    parameter int NREG  = DEF_NREG,
    parameter int XLEN  = DEF_XLEN,
    parameter int TAG_W = DEF_TAG_W,
    parameter int NRD   = DEF_NRD,
    parameter int PAY_W = DEF_PAY_W
);
    localparam int RW = reg_w(NREG);

    logic                           rdy;
    logic                           flush;
    logic                           in_valid;
    logic                           in_ready;
    logic [NRD-1:0][RW-1:0]         in_rs;
    logic [RW-1:0]                  in_rd;
    logic                           in_rd_we;
    logic [TAG_W-1:0]               in_tag;
    logic [PAY_W-1:0]               in_pay;
    logic                           cm_valid;
    logic [RW-1:0]                  cm_rd;
    logic [TAG_W-1:0]               cm_tag;
    logic [XLEN-1:0]                cm_dt;
    logic                           out_valid;
    logic                           out_ready;
    logic [NRD-1:0][XLEN-1:0]       out_rs_dt;
    logic [NRD-1:0][TAG_W-1:0]      out_rs_tag;
    logic [RW-1:0]                  out_rd;
    logic [TAG_W-1:0]               out_tag;
    logic                           out_rd_we;
    logic [PAY_W-1:0]               out_pay;

    modport master (
        output rdy, flush, in_valid, in_rs, in_rd, in_rd_we, in_tag, in_pay,
               cm_valid, cm_rd, cm_tag, cm_dt, out_ready,
        input  in_ready, out_valid, out_rs_dt, out_rs_tag, out_rd, out_tag,
               out_rd_we, out_pay
    );

    modport slave (
        input  rdy, flush, in_valid, in_rs, in_rd, in_rd_we, in_tag, in_pay,
               cm_valid, cm_rd, cm_tag, cm_dt, out_ready,
        output in_ready, out_valid, out_rs_dt, out_rs_tag, out_rd, out_tag,
               out_rd_we, out_pay
    );
endinterface

// File: rtl/rename_regfile_read_port.sv
// One source read port: {value, tag} with x0 forced to zero. Defining
// RENAME_RF_BYPASS_EN forwards a same-cycle matching commit into the read.
module rf_read_port
    import rename_rf_pkg::*;
#(
    parameter int NREG  = DEF_NREG,
    parameter int XLEN  = DEF_XLEN,
    parameter int TAG_W = DEF_TAG_W,
    parameter int RW    = reg_w(NREG)
) (
    input  logic [RW-1:0]    i_rs,
    input  logic [XLEN-1:0]  i_data [NREG],
    input  logic [TAG_W-1:0] i_tag  [NREG],
    input  logic             i_cm_en,
    input  logic [RW-1:0]    i_cm_rd,
    input  logic [TAG_W-1:0] i_cm_tag,
    input  logic [XLEN-1:0]  i_cm_dt,
    output logic [XLEN-1:0]  o_dt,
    output logic [TAG_W-1:0] o_tag
);
`ifdef RENAME_RF_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [XLEN-1:0]  w_dt;
    logic [TAG_W-1:0] w_tag;
    logic             w_hit;

    assign w_dt  = i_data[i_rs];
    assign w_tag = i_tag[i_rs];
    // Forwarding yields exactly what next cycle's read would see.
    assign w_hit = BYPASS && i_cm_en && (i_cm_rd == i_rs) && (w_tag == i_cm_tag);

    always_comb begin
        o_dt  = w_dt;
        o_tag = w_tag;
        if (i_rs == '0) begin
            o_dt  = '0;
            o_tag = TAG_W'(TAG_NONE);
        end else if (w_hit) begin
            o_dt  = i_cm_dt;
            o_tag = TAG_W'(TAG_NONE);
        end
    end
endmodule

// File: rtl/rename_regfile.sv
// Architectural register file with rename tags and a one-entry registered
// dispatch stage. Optional same-cycle commit bypass: RENAME_RF_BYPASS_EN.
module rename_regfile
    import rename_rf_pkg::*;
#(
    parameter int NREG  = DEF_NREG,
    parameter int XLEN  = DEF_XLEN,
    parameter int TAG_W = DEF_TAG_W,
    parameter int NRD   = DEF_NRD,
    parameter int PAY_W = DEF_PAY_W
) (
    input  logic             clk,
    input  logic             rst_n,
    rename_regfile_if.slave  bus
);
    localparam int RW = reg_w(NREG);

    logic [XLEN-1:0]  r_data [NREG];
    logic [TAG_W-1:0] r_tag  [NREG];

    logic             r_out_valid;
    logic [RW-1:0]    r_out_rd;
    logic [TAG_W-1:0] r_out_tag;
    logic             r_out_rd_we;
    logic [PAY_W-1:0] r_out_pay;

    logic w_in_ready;
    logic w_accept;
    logic w_rename;
    logic w_cm_en;

    assign w_in_ready = bus.rdy & ~bus.flush & (~r_out_valid | bus.out_ready);
    assign w_accept   = bus.in_valid & w_in_ready;
    assign w_rename   = w_accept & bus.in_rd_we & (bus.in_rd != '0);
    assign w_cm_en    = bus.cm_valid & bus.rdy & (bus.cm_rd != '0);

    // Entry 0 is only ever reset, so it stays zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_data[i] <= '0;
                r_tag[i]  <= '0;
            end
        end else if (bus.rdy) begin
            for (int i = 1; i < NREG; i++) begin
                if (w_cm_en && bus.cm_rd == RW'(i))
                    r_data[i] <= bus.cm_dt;
                if (bus.flush)
                    r_tag[i] <= '0;
                else if (w_rename && bus.in_rd == RW'(i))
                    r_tag[i] <= bus.in_tag;
                else if (w_cm_en && bus.cm_rd == RW'(i) && r_tag[i] == bus.cm_tag)
                    r_tag[i] <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_rd    <= '0;
            r_out_tag   <= '0;
            r_out_rd_we <= 1'b0;
            r_out_pay   <= '0;
        end else if (bus.rdy) begin
            if (bus.flush) begin
                r_out_valid <= 1'b0;
            end else if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_rd    <= bus.in_rd;
                r_out_tag   <= bus.in_tag;
                r_out_rd_we <= bus.in_rd_we;
                r_out_pay   <= bus.in_pay;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NRD; gi++) begin : g_port
            logic [XLEN-1:0]  w_dt;
            logic [TAG_W-1:0] w_tg;
            logic [XLEN-1:0]  r_dt;
            logic [TAG_W-1:0] r_tg;

            rf_read_port #(.NREG(NREG), .XLEN(XLEN), .TAG_W(TAG_W), .RW(RW)) u_read (
                .i_rs     (bus.in_rs[gi]),
                .i_data   (r_data),
                .i_tag    (r_tag),
                .i_cm_en  (w_cm_en),
                .i_cm_rd  (bus.cm_rd),
                .i_cm_tag (bus.cm_tag),
                .i_cm_dt  (bus.cm_dt),
                .o_dt     (w_dt),
                .o_tag    (w_tg)
            );

            // A held entry keeps listening to the commit bus for its tag.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_dt <= '0;
                    r_tg <= '0;
                end else if (bus.rdy && !bus.flush) begin
                    if (w_accept) begin
                        r_dt <= w_dt;
                        r_tg <= w_tg;
                    end else if (r_out_valid && bus.cm_valid && r_tg != '0 && r_tg == bus.cm_tag) begin
                        r_dt <= bus.cm_dt;
                        r_tg <= '0;
                    end
                end
            end

            assign bus.out_rs_dt[gi]  = r_dt;
            assign bus.out_rs_tag[gi] = r_tg;
        end
    endgenerate

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_rd    = r_out_rd;
    assign bus.out_tag   = r_out_tag;
    assign bus.out_rd_we = r_out_rd_we;
    assign bus.out_pay   = r_out_pay;
endmodule

// File: tb/tb_rename_regfile.sv
// Directed scenarios with constant expectations, then randomized traffic
// checked against an array-based reference model of the register file.
module tb_rename_regfile;
    import rename_rf_pkg::*;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   passes = 0;

    rename_regfile_if #(.NREG(32), .XLEN(32), .TAG_W(4), .NRD(2), .PAY_W(64)) bus ();

    rename_regfile #(.NREG(32), .XLEN(32), .TAG_W(4), .NRD(2), .PAY_W(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state
    logic [31:0] m_data [32];
    logic [3:0]  m_tag  [32];
    logic        m_ov;
    logic [31:0] m_dt   [2];
    logic [3:0]  m_tg   [2];
    logic [4:0]  m_rd;
    logic [3:0]  m_otag;
    logic        m_we;
    pay_t        m_pay;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.cm_valid = 1'b0;
        bus.flush    = 1'b0;
    endtask

    task automatic offer(input logic [4:0] rs0, input logic [4:0] rs1, input logic [4:0] rd,
                         input logic we, input logic [3:0] tag);
        bus.in_valid = 1'b1;
        bus.in_rs[0] = rs0;
        bus.in_rs[1] = rs1;
        bus.in_rd    = rd;
        bus.in_rd_we = we;
        bus.in_tag   = tag;
        bus.in_pay   = {$urandom, $urandom};
    endtask

    task automatic commit(input logic [4:0] rd, input logic [3:0] tag, input logic [31:0] dt);
        bus.cm_valid = 1'b1;
        bus.cm_rd    = rd;
        bus.cm_tag   = tag;
        bus.cm_dt    = dt;
    endtask

    task automatic test_reset();
        pay_t p;
        rst_n = 1'b0;
        bus.rdy = 1'b1; bus.out_ready = 1'b1;
        bus.in_rs = '0; bus.in_rd = '0; bus.in_rd_we = 1'b0; bus.in_tag = '0; bus.in_pay = '0;
        bus.cm_rd = '0; bus.cm_tag = '0; bus.cm_dt = '0;
        idle();
        repeat (3) tick();
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", bus.out_valid); else passes++;
        checks++; if (bus.out_rs_tag !== 8'h00 || bus.out_rs_dt !== 64'h0) $display("FAIL reset_out got %h/%h want 0/0", bus.out_rs_dt, bus.out_rs_tag); else passes++;
        rst_n = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", bus.in_ready); else passes++;
        offer(5'd1, 5'd2, 5'd0, 1'b0, 4'd0);
        p = bus.in_pay;
        tick();
        checks++; if (bus.out_valid !== 1'b1) $display("FAIL simple_valid got %b want 1", bus.out_valid); else passes++;
        checks++; if (bus.out_rs_dt !== 64'h0 || bus.out_rs_tag !== 8'h00) $display("FAIL simple_read got %h/%h want 0/0", bus.out_rs_dt, bus.out_rs_tag); else passes++;
        checks++; if (bus.out_pay !== p) $display("FAIL simple_pay got %h want %h", bus.out_pay, p); else passes++;
        idle();
        tick();
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL drain_valid got %b want 0", bus.out_valid); else passes++;
        $display("test_reset done");
    endtask

    task automatic test_rename_read();
        offer(5'd5, 5'd0, 5'd5, 1'b1, 4'd3);
        tick();
        checks++; if (bus.out_rs_tag[0] !== 4'd0) $display("FAIL own_tag got %0d want 0", bus.out_rs_tag[0]); else passes++;
        checks++; if (bus.out_rd !== 5'd5 || bus.out_tag !== 4'd3 || bus.out_rd_we !== 1'b1) $display("FAIL out_rd got %0d/%0d/%b want 5/3/1", bus.out_rd, bus.out_tag, bus.out_rd_we); else passes++;
        offer(5'd5, 5'd0, 5'd0, 1'b0, 4'd0);
        tick();
        checks++; if (bus.out_rs_tag[0] !== 4'd3) $display("FAIL dep_tag got %0d want 3", bus.out_rs_tag[0]); else passes++;
        idle();
        commit(5'd5, 4'd3, 32'hDEAD);
        tick();
        idle();
        offer(5'd5, 5'd5, 5'd0, 1'b0, 4'd0);
        tick();
        checks++; if (bus.out_rs_dt[0] !== 32'hDEAD || bus.out_rs_tag[0] !== 4'd0 || bus.out_rs_dt[1] !== 32'hDEAD) $display("FAIL commit_read got %h/%0d want dead/0", bus.out_rs_dt[0], bus.out_rs_tag[0]); else passes++;
        $display("test_rename_read done");
    endtask

    task automatic test_stale_commit();
        offer(5'd0, 5'd0, 5'd5, 1'b1, 4'd7);
        tick();
        idle();
        commit(5'd5, 4'd3, 32'h11);
        tick();
        idle();
        offer(5'd5, 5'd6, 5'd0, 1'b0, 4'd0);
        tick();
        checks++; if (bus.out_rs_dt[0] !== 32'h11 || bus.out_rs_tag[0] !== 4'd7) $display("FAIL stale_commit got %h/%0d want 11/7", bus.out_rs_dt[0], bus.out_rs_tag[0]); else passes++;
        offer(5'd0, 5'd0, 5'd6, 1'b1, 4'd2);
        tick();
        offer(5'd0, 5'd0, 5'd6, 1'b1, 4'd9);
        commit(5'd6, 4'd2, 32'h66);
        tick();
        idle();
        offer(5'd6, 5'd0, 5'd0, 1'b0, 4'd0);
        tick();
        checks++; if (bus.out_rs_dt[0] !== 32'h66 || bus.out_rs_tag[0] !== 4'd9) $display("FAIL rename_wins got %h/%0d want 66/9", bus.out_rs_dt[0], bus.out_rs_tag[0]); else passes++;
        $display("test_stale_commit done");
    endtask

    task automatic test_bypass();
        logic [31:0] exp_dt;
        logic [3:0]  exp_tg;
`ifdef RENAME_RF_BYPASS_EN
        exp_dt = 32'h42; exp_tg = 4'd0;
`else
        exp_dt = 32'h11; exp_tg = 4'd3;
`endif
        offer(5'd0, 5'd0, 5'd5, 1'b1, 4'd3);
        tick();
        offer(5'd5, 5'd1, 5'd0, 1'b0, 4'd0);
        commit(5'd5, 4'd3, 32'h42);
        tick();
        idle();
        checks++; if (bus.out_rs_dt[0] !== exp_dt || bus.out_rs_tag[0] !== exp_tg) $display("FAIL bypass got %h/%0d want %h/%0d", bus.out_rs_dt[0], bus.out_rs_tag[0], exp_dt, exp_tg); else passes++;
        offer(5'd5, 5'd0, 5'd0, 1'b0, 4'd0);
        tick();
        checks++; if (bus.out_rs_dt[0] !== 32'h42 || bus.out_rs_tag[0] !== 4'd0) $display("FAIL post_bypass got %h/%0d want 42/0", bus.out_rs_dt[0], bus.out_rs_tag[0]); else passes++;
        $display("test_bypass done");
    endtask

    task automatic test_stall_snoop();
        pay_t p;
        offer(5'd0, 5'd0, 5'd7, 1'b1, 4'd4);
        tick();
        idle();
        tick();
        offer(5'd7, 5'd5, 5'd0, 1'b0, 4'd0);
        p = bus.in_pay;
        bus.out_ready = 1'b0;
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_rs_tag[0] !== 4'd4 || bus.out_rs_dt[1] !== 32'h42) $display("FAIL stall_load got %b/%0d/%h want 1/4/42", bus.out_valid, bus.out_rs_tag[0], bus.out_rs_dt[1]); else passes++;
        offer(5'd0, 5'd0, 5'd3, 1'b1, 4'd8);
        #1;
        checks++; if (bus.in_ready !== 1'b0) $display("FAIL stall_in_ready got %b want 0", bus.in_ready); else passes++;
        tick();
        checks++; if (bus.out_rd !== 5'd0 || bus.out_rs_tag[0] !== 4'd4 || bus.out_pay !== p) $display("FAIL stall_hold got rd %0d tag %0d want 0/4", bus.out_rd, bus.out_rs_tag[0]); else passes++;
        commit(5'd7, 4'd4, 32'h99);
        tick();
        bus.cm_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_rs_dt[0] !== 32'h99 || bus.out_rs_tag[0] !== 4'd0) $display("FAIL snoop got %b/%h/%0d want 1/99/0", bus.out_valid, bus.out_rs_dt[0], bus.out_rs_tag[0]); else passes++;
        bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) $display("FAIL unstall_in_ready got %b want 1", bus.in_ready); else passes++;
        tick();
        checks++; if (bus.out_rd !== 5'd3 || bus.out_tag !== 4'd8) $display("FAIL unstall_accept got %0d/%0d want 3/8", bus.out_rd, bus.out_tag); else passes++;
        idle();
        tick();
        $display("test_stall_snoop done");
    endtask

    task automatic test_flush();
        offer(5'd0, 5'd0, 5'd1, 1'b1, 4'd1); tick();
        offer(5'd0, 5'd0, 5'd2, 1'b1, 4'd2); tick();
        offer(5'd0, 5'd0, 5'd3, 1'b1, 4'd3); tick();
        offer(5'd1, 5'd2, 5'd4, 1'b1, 4'd5);
        commit(5'd2, 4'd2, 32'h222);
        bus.flush = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b0) $display("FAIL flush_in_ready got %b want 0", bus.in_ready); else passes++;
        tick();
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL flush_valid got %b want 0", bus.out_valid); else passes++;
        idle();
        tick();
        offer(5'd1, 5'd2, 5'd0, 1'b0, 4'd0);
        tick();
        checks++; if (bus.out_rs_tag !== 8'h00 || bus.out_rs_dt[1] !== 32'h222) $display("FAIL flush_tags got %h/%h want 00/222", bus.out_rs_tag, bus.out_rs_dt[1]); else passes++;
        offer(5'd3, 5'd4, 5'd0, 1'b0, 4'd0);
        tick();
        checks++; if (bus.out_rs_tag !== 8'h00) $display("FAIL flush_no_accept got %h want 00", bus.out_rs_tag); else passes++;
        offer(5'd0, 5'd0, 5'd0, 1'b1, 4'd6);
        commit(5'd0, 4'd6, 32'h55);
        tick();
        idle();
        offer(5'd0, 5'd0, 5'd0, 1'b0, 4'd0);
        tick();
        checks++; if (bus.out_rs_dt !== 64'h0 || bus.out_rs_tag !== 8'h00) $display("FAIL x0 got %h/%h want 0/0", bus.out_rs_dt, bus.out_rs_tag); else passes++;
        idle();
        $display("test_flush done");
    endtask

    task automatic test_rdy_low();
        offer(5'd7, 5'd0, 5'd0, 1'b0, 4'd0);
        tick();
        bus.rdy = 1'b0;
        commit(5'd7, 4'd0, 32'h1234);
        offer(5'd0, 5'd0, 5'd7, 1'b1, 4'd5);
        #1;
        checks++; if (bus.in_ready !== 1'b0) $display("FAIL rdy_in_ready got %b want 0", bus.in_ready); else passes++;
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_rs_dt[0] !== 32'h99) $display("FAIL rdy_freeze got %b/%h want 1/99", bus.out_valid, bus.out_rs_dt[0]); else passes++;
        bus.rdy = 1'b1;
        idle();
        tick();
        offer(5'd7, 5'd0, 5'd0, 1'b0, 4'd0);
        tick();
        checks++; if (bus.out_rs_dt[0] !== 32'h99 || bus.out_rs_tag[0] !== 4'd0) $display("FAIL rdy_commit_ignored got %h/%0d want 99/0", bus.out_rs_dt[0], bus.out_rs_tag[0]); else passes++;
        idle();
        $display("test_rdy_low done");
    endtask

    task automatic test_async_reset();
        offer(5'd0, 5'd0, 5'd9, 1'b1, 4'd5);
        tick();
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL async_reset_valid got %b want 0", bus.out_valid); else passes++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        offer(5'd9, 5'd5, 5'd0, 1'b0, 4'd0);
        tick();
        checks++; if (bus.out_rs_tag !== 8'h00 || bus.out_rs_dt !== 64'h0) $display("FAIL async_reset_state got %h/%h want 0/0", bus.out_rs_dt, bus.out_rs_tag); else passes++;
        idle();
        tick();
        $display("test_async_reset done");
    endtask

    task automatic test_random(input int n);
        logic        exp_ready;
        logic        acc;
        logic [31:0] rv [2];
        logic [3:0]  rt [2];
        logic [4:0]  r;
        for (int i = 0; i < 32; i++) begin
            m_data[i] = '0;
            m_tag[i]  = '0;
        end
        m_ov = 1'b0;
        for (int c = 0; c < n; c++) begin
            bus.rdy       = ($urandom_range(9) != 0);
            bus.flush     = ($urandom_range(19) == 0);
            bus.in_valid  = ($urandom_range(9) < 7);
            bus.in_rs[0]  = 5'($urandom_range(7));
            bus.in_rs[1]  = 5'($urandom_range(7));
            bus.in_rd     = 5'($urandom_range(7));
            bus.in_rd_we  = ($urandom_range(9) < 7);
            bus.in_tag    = 4'($urandom_range(15, 1));
            bus.in_pay    = {$urandom, $urandom};
            bus.cm_valid  = ($urandom_range(9) < 4);
            bus.cm_rd     = 5'($urandom_range(7));
            bus.cm_tag    = ($urandom_range(1) != 0) ? m_tag[bus.cm_rd] : 4'($urandom_range(15, 1));
            bus.cm_dt     = $urandom;
            bus.out_ready = ($urandom_range(9) < 7);
            #1;
            exp_ready = bus.rdy && !bus.flush && (!m_ov || bus.out_ready);
            checks++; if (bus.in_ready !== exp_ready) $display("FAIL rnd_in_ready c%0d got %b want %b", c, bus.in_ready, exp_ready); else passes++;
            acc = bus.in_valid && exp_ready;
            for (int k = 0; k < 2; k++) begin
                r = bus.in_rs[k];
                rv[k] = (r == 0) ? 32'h0 : m_data[r];
                rt[k] = (r == 0) ? 4'h0  : m_tag[r];
`ifdef RENAME_RF_BYPASS_EN
                if (r != 0 && bus.cm_valid && bus.rdy && bus.cm_rd == r && m_tag[r] == bus.cm_tag) begin
                    rv[k] = bus.cm_dt;
                    rt[k] = 4'h0;
                end
`endif
            end
            if (bus.rdy) begin
                if (bus.flush) begin
                    m_ov = 1'b0;
                end else if (acc) begin
                    m_ov = 1'b1; m_dt = rv; m_tg = rt;
                    m_rd = bus.in_rd; m_otag = bus.in_tag; m_we = bus.in_rd_we; m_pay = bus.in_pay;
                    $display("rnd c%0d accept rs=%0d,%0d rd=%0d we=%b tag=%0d", c, bus.in_rs[0], bus.in_rs[1], bus.in_rd, bus.in_rd_we, bus.in_tag);
                end else begin
                    for (int k = 0; k < 2; k++)
                        if (m_ov && bus.cm_valid && m_tg[k] != 0 && m_tg[k] == bus.cm_tag) begin
                            m_dt[k] = bus.cm_dt;
                            m_tg[k] = 4'h0;
                        end
                    if (bus.out_ready) m_ov = 1'b0;
                end
                if (bus.cm_valid && bus.cm_rd != 0) begin
                    m_data[bus.cm_rd] = bus.cm_dt;
                    if (m_tag[bus.cm_rd] == bus.cm_tag && !(acc && bus.in_rd_we && bus.in_rd == bus.cm_rd))
                        m_tag[bus.cm_rd] = 4'h0;
                end
                if (acc && bus.in_rd_we && bus.in_rd != 0) m_tag[bus.in_rd] = bus.in_tag;
                if (bus.flush)
                    for (int i = 0; i < 32; i++) m_tag[i] = 4'h0;
            end
            @(posedge clk);
            #1;
            checks++; if (bus.out_valid !== m_ov) $display("FAIL rnd_valid c%0d got %b want %b", c, bus.out_valid, m_ov); else passes++;
            if (m_ov) begin
                for (int k = 0; k < 2; k++) begin
                    checks++; if (bus.out_rs_dt[k] !== m_dt[k] || bus.out_rs_tag[k] !== m_tg[k]) $display("FAIL rnd_src%0d c%0d got %h/%0d want %h/%0d", k, c, bus.out_rs_dt[k], bus.out_rs_tag[k], m_dt[k], m_tg[k]); else passes++;
                end
                checks++; if (bus.out_rd !== m_rd || bus.out_tag !== m_otag || bus.out_rd_we !== m_we || bus.out_pay !== m_pay) $display("FAIL rnd_dest c%0d got %0d/%0d/%b want %0d/%0d/%b", c, bus.out_rd, bus.out_tag, bus.out_rd_we, m_rd, m_otag, m_we); else passes++;
            end
        end
        idle();
        bus.rdy = 1'b1;
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_rename_read();
        test_stale_commit();
        test_bypass();
        test_stall_snoop();
        test_flush();
        test_rdy_low();
        test_async_reset();
        test_random(400);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
